// File: rtl/hs_pkg.sv
// Shared definitions for the hs receive-side sequence checker.
// Holds the default word width and sequence limit, the checker state type,
// and the wrap rule used to predict the next word in the stream.
package hs_pkg;

  localparam int HS_DATA_W  = 4;
  localparam int HS_SEQ_MAX = 7;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } hs_state_t;

  // Successor of x in the 0..max_val wrapping sequence. Values at or above
  // max_val (including out-of-range ones) restart the sequence at zero.
  function automatic logic [31:0] seq_next(input logic [31:0] x, input logic [31:0] max_val);
    return (x >= max_val) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Small single-clock FIFO for received words.
// Pointers carry one extra bit so full and empty differ only in that MSB.
// The head word is read combinationally and forced to zero while empty, so
// the consumer sees a clean zero after reset and a stable word while stalled.
module hs_sync_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic              wr_en;
  logic              rd_en;

  assign wr_addr = wr_ptr_reg[AW-1:0];
  assign rd_addr = rd_ptr_reg[AW-1:0];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = empty ? '0 : mem_reg[rd_addr];

  // Storage write; no reset needed because the head is masked while empty.
  always_ff @(posedge clk_b) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= din;
    end
  end

  // Pointer update, wrapping naturally through the extra MSB.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

endmodule

// File: rtl/hs_rx_seq_checker.sv
// Receive-side buffer and sequence checker, clk_b domain.
// Buffers strobed words in hs_sync_fifo, hands them out over valid/ready and
// checks the stream against the 0..MAX_VAL wrapping sequence.
// Build option: define HS_RX_SEQ_STATS_EN to implement word_cnt / err_cnt;
// otherwise both ports are tied to zero.
module hs_rx_seq_checker
  import hs_pkg::*;
#(
  parameter int DATA_W  = HS_DATA_W,
  parameter int MAX_VAL = HS_SEQ_MAX,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              err_clr,
  output logic              seq_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [31:0] MAX_U = 32'(MAX_VAL);

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              drop;

  hs_state_t         state_reg;
  hs_state_t         state_next;
  logic [DATA_W-1:0] exp_reg;
  logic [DATA_W-1:0] exp_next;
  logic              mismatch;
  logic              seq_err_reg;
  logic              overflow_reg;

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign drop      = in_valid && fifo_full && !fifo_pop;

  hs_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_b (clk_b),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_data),
    .pop   (fifo_pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Checker state and expected-value register.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_reg <= HUNT;
      exp_reg   <= '0;
    end else begin
      state_reg <= state_next;
      exp_reg   <= exp_next;
    end
  end

  // Next-state logic: a word strobed together with err_clr is not checked.
  // Mismatches resync on the received word, so a single gap costs one error.
  always_comb begin
    state_next = state_reg;
    exp_next   = exp_reg;
    mismatch   = 1'b0;
    if (err_clr) begin
      state_next = HUNT;
    end else if (in_valid) begin
      exp_next = DATA_W'(seq_next(32'(in_data), MAX_U));
      case (state_reg)
        HUNT: begin
          state_next = LOCK;
        end
        LOCK: begin
          if ((in_data != exp_reg) || (32'(in_data) > MAX_U)) begin
            mismatch = 1'b1;
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      seq_err_reg <= 1'b0;
    end else begin
      seq_err_reg <= mismatch;
    end
  end

  // Sticky overflow; a drop in the clearing cycle still records itself.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (err_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign seq_err  = seq_err_reg;
  assign overflow = overflow_reg;

`ifdef HS_RX_SEQ_STATS_EN
  logic [CNT_W-1:0] word_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  // Saturating statistics; err_cnt moves in the same edge that raises seq_err.
  always_ff @(posedge clk_b) begin
    if (rst || err_clr) begin
      word_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (in_valid && (word_cnt_reg != '1)) begin
        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      end
      if (mismatch && (err_cnt_reg != '1)) begin
        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign word_cnt = word_cnt_reg;
  assign err_cnt  = err_cnt_reg;
`else
  assign word_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_hs_rx_seq_checker.sv
// Scoreboard bench for hs_rx_seq_checker: stimulus pushes expected words,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_hs_rx_seq_checker;

`ifdef HS_RX_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk_b = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       out_valid;
  logic [3:0] out_data;
  logic       seq_err;
  logic       overflow;
  logic [7:0] word_cnt;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;
  logic [3:0] sb[$];

  hs_rx_seq_checker #(
    .DATA_W  (4),
    .MAX_VAL (7),
    .DEPTH   (4),
    .CNT_W   (8)
  ) dut (
    .clk_b     (clk_b),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_clr   (err_clr),
    .seq_err   (seq_err),
    .overflow  (overflow),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk_b = ~clk_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // Monitor: compares each delivered word against the scoreboard head.
  always @(negedge clk_b) begin : mon
    logic [3:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_data_unexpected: got %0d expected none", out_data);
      end else begin
        e = sb.pop_front();
        $display("xfer out_data=%0d expected=%0d", out_data, e);
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
  end

  // One clock of stimulus; seq_err sampled after the edge belongs to this word.
  task automatic step(input logic v, input logic [3:0] d, input logic rdy,
                      input logic clr, input logic exp_err, input logic exp_push);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    err_clr   = clr;
    if (exp_push) sb.push_back(d);
    @(posedge clk_b);
    #1;
    chk("seq_err", 32'(seq_err), 32'(exp_err));
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic word(input logic [3:0] d, input logic rdy, input logic exp_err);
    step(1'b1, d, rdy, 1'b0, exp_err, 1'b1);
  endtask

  task automatic clear();
    step(1'b0, 4'd0, out_ready, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 16) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] seq_a [5];
    logic [3:0] seq_b [6];
    logic       err_b [6];
    seq_a = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5};
    seq_b = '{4'd6, 4'd7, 4'd0, 4'd1, 4'd9, 4'd0};
    err_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    // Clean stream 0..7 twice, 1-cycle latency
    for (int i = 0; i < 16; i++) begin
      word(4'(i % 8), 1'b1, 1'b0);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'(i % 8));
    end
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stream_empty", 32'(out_valid), 32'd0);
    chk("stream_word_cnt", 32'(word_cnt), cnt(16));
    chk("stream_err_cnt", 32'(err_cnt), cnt(0));

    // Gap 2->4: one error, resync on 5
    clear();
    for (int i = 0; i < 5; i++) word(seq_a[i], 1'b1, (i == 3));
    chk("gap_word_cnt", 32'(word_cnt), cnt(5));
    chk("gap_err_cnt", 32'(err_cnt), cnt(1));
    drain();

    // Wrap 6,7,0,1 clean; out-of-range 9 flagged; 0 after resync clean
    clear();
    for (int i = 0; i < 6; i++) word(seq_b[i], 1'b1, err_b[i]);
    chk("wrap_err_cnt", 32'(err_cnt), cnt(1));
    chk("wrap_word_cnt", 32'(word_cnt), cnt(6));
    drain();

    // Overflow: 4 stored, 5th dropped, sticky
    clear();
    for (int i = 2; i < 6; i++) word(4'(i), 1'b0, 1'b0);
    chk("full_head", 32'(out_data), 32'd2);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (2) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("stall_head", 32'(out_data), 32'd2);
    clear();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_keep_head", 32'(out_data), 32'd2);

    // Full with simultaneous pop: accepted, no overflow, still full
    word(4'd7, 1'b1, 1'b0);
    chk("fullpop_no_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(out_data), 32'd3);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("still_full_drop", 32'(overflow), 32'd1);
    drain();

    // err_clr with contents held and a word in the clear cycle
    word(4'd1, 1'b0, 1'b0);
    word(4'd2, 1'b0, 1'b0);
    word(4'd5, 1'b0, 1'b1);
    chk("pre_clr_word_cnt", 32'(word_cnt), cnt(5));
    chk("pre_clr_err_cnt", 32'(err_cnt), cnt(1));
    step(1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_word_cnt", 32'(word_cnt), cnt(0));
    chk("clr_err_cnt", 32'(err_cnt), cnt(0));
    chk("clr_fifo_valid", 32'(out_valid), 32'd1);
    chk("clr_fifo_head", 32'(out_data), 32'd1);
    word(4'd3, 1'b1, 1'b0);
    chk("post_clr_word_cnt", 32'(word_cnt), cnt(1));
    chk("post_clr_head", 32'(out_data), 32'd2);
    drain();

    // Mid-stream reset
    word(4'd4, 1'b0, 1'b0);
    word(4'd5, 1'b0, 1'b0);
    sb.delete();
    rst = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    word(4'd9, 1'b1, 1'b0);
    chk("hunt_valid", 32'(out_valid), 32'd1);
    chk("hunt_data", 32'(out_data), 32'd9);
    word(4'd0, 1'b1, 1'b0);
    chk("hunt_word_cnt", 32'(word_cnt), cnt(2));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
